matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Byte-stream controller for the UART matrix-multiply path. It sits between the UART receiver and transmitter. It assembles received bytes into 32-bit words and loads dimensions M, N, P and matrices A and B. It then sequences a single shared multiply-accumulate over the stored operands and streams result matrix C back out as bytes under a valid/ready handshake.

## Interface
- MAX_M, default 4: maximum rows of A and C.
- MAX_N, default 4: maximum columns of A and rows of B.
- MAX_P, default 4: maximum columns of B and C.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte in this cycle.
- busy  out  1  high during COMPUTE and SEND.
- done  out  1  one-cycle pulse after the last byte of C is accepted.
- err  out  1  one-cycle pulse when a header dimension is rejected.

## Operation
- Word assembly: 4 bytes per word, MSB first: word = {word[23:0], rx_data}. The byte counter (0..3) is cleared on every state change.
- States:
  - HDR: collect 3 words, M then N then P. When a word completes, it must be in the range 1..MAX. An out-of-range word pulses err, discards any dimensions already accepted, and restarts HDR at the M word. Acceptance of P moves the block to LOAD_A.
  - LOAD_A: M*N words, stored row-major into A[i][k].
  - LOAD_B: N*P words, stored row-major into B[k][j].
  - COMPUTE: indices i (outer), j, k (inner), one k step per cycle.
    - acc_next = (k==0 ? 0 : acc) + A[i][k]*B[k][j], keeping the low 32 bits (unsigned, modulo 2^32).
    - When k==N-1, write acc_next to C[i][j].
    - After i=M-1, j=P-1, k=N-1, go to SEND.
  - SEND: C in row-major order, 4 bytes per element, MSB first.
    - tx_data/tx_valid are registered.
    - tx_data is held stable while tx_valid=1 and tx_ready=0.
    - A byte is consumed on tx_valid & tx_ready, and the next byte is presented in the following cycle.
    - After the final byte is consumed, pulse done and return to HDR.
- rx_valid is ignored (byte dropped) in COMPUTE and SEND.
- A, B, C storage is not cleared by reset. Entries outside the active M/N/P are don't-care and are never transmitted.
- Resource constraint: exactly one 32x32 multiplier is instantiated.

## Timing
- Reset: state=HDR, all counters=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0.
- Reset asserted mid-operation: the block aborts immediately and does not pulse done. Partial words are discarded.
- A word completes in the cycle its 4th byte arrives with rx_valid=1. The state change takes effect on that edge.
- Last B byte strobe at cycle t: COMPUTE runs in cycles t+1 .. t+M*N*P, so busy rises at t+1. C[M-1][P-1] is written at the end of cycle t+M*N*P.
- First tx_valid=1 occurs at cycle t+M*N*P+1.
- Output rate with tx_ready held high: one byte per 2 cycles (valid, accept, re-present). SEND therefore spans 8*M*P cycles minimum.
- done is high for exactly one cycle, the cycle after the final accept. busy falls in that same cycle, and the block is in HDR.
- err is high for the cycle after the offending word completes. The next rx byte is treated as byte 0 of M.
- Boundary: M=N=P=1 gives 1 COMPUTE cycle and 4 output bytes. The MAX,MAX,MAX case must index without overflow; counter widths are clog2(MAX)+1.

## Test plan
- Basic 2x2:
  - Stimulus: header 2,2,2; A=1,2,3,4; B=5,6,7,8; tx_ready=1.
  - Required: busy high for exactly 8 cycles of COMPUTE. Output bytes are 00 00 00 13, 00 00 00 16, 00 00 00 2B, 00 00 00 32 (C = 19, 22, 43, 50). done pulses once.
- Non-square 1x4x1:
  - Stimulus: A=1,2,3,4; B=10,20,30,40.
  - Required: single result 0x0000012C (300). Exactly 4 bytes transmitted.
- Wrap-around:
  - Stimulus: 1,1,1 with A=0xFFFFFFFF, B=2.
  - Required: output bytes FF FF FF FE.
- Header rejection:
  - Stimulus: send M=0, then M=5 (with MAX_M=4), then a valid 2,2,2 job.
  - Required: err pulses twice, no tx activity from the rejected words. The subsequent job produces the correct 2x2 result.
- Backpressure:
  - Stimulus: tx_ready randomly low (~50%) during SEND, plus rx bytes injected during COMPUTE and SEND.
  - Required: tx_data never changes while tx_valid=1 and tx_ready=0. The byte sequence is identical to the first scenario, and the injected rx bytes have no effect.
- Reset mid-SEND:
  - Stimulus: assert rst after 5 bytes of C have been accepted.
  - Required: tx_valid, busy and done are 0 immediately. A following full 2x2 job completes correctly.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Byte-stream bus for the matmul sequencer.
// Carries UART rx bytes in and C bytes out, plus status strobes.
interface matmul_sequencer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_data, tx_valid, busy, done, err
  );

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_data, tx_valid, busy, done, err
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Loads M/N/P and A, B from a byte stream and runs one shared MAC.
// Streams C back out MSB-first under a valid/ready handshake.
module matmul_sequencer #(
  parameter int MAX_M = 4,
  parameter int MAX_N = 4,
  parameter int MAX_P = 4
) (
  input  logic               clk,
  input  logic               rst,
  matmul_sequencer_if.slave  bus
);
  localparam int MW = $clog2(MAX_M) + 1;
  localparam int NW = $clog2(MAX_N) + 1;
  localparam int PW = $clog2(MAX_P) + 1;
  localparam int MA = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int NA = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int PA = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [2:0] {
    HDR, LOAD_A, LOAD_B, COMPUTE, SEND
  } state_t;

  state_t        state_q;
  logic [1:0]    bcnt_q, hcnt_q;
  logic [23:0]   word_q;
  logic [31:0]   acc_q;
  logic [MW-1:0] m_q, i_q;
  logic [NW-1:0] n_q, k_q;
  logic [PW-1:0] p_q, j_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q, busy_q;
  logic          done_q, err_q;

  logic [31:0] a_q [0:(1<<MA)-1][0:(1<<NA)-1];
  logic [31:0] b_q [0:(1<<NA)-1][0:(1<<PA)-1];
  logic [31:0] c_q [0:(1<<MA)-1][0:(1<<PA)-1];

  logic [31:0]   word_d, acc_d, prod, lim;
  logic [31:0]   c_rd, c_first;
  logic [7:0]    byte_sel;
  logic          loading, wdone, dim_ok;
  logic          i_last, j_last, k_last;
  logic [MA-1:0] ai;
  logic [NA-1:0] ak;
  logic [PA-1:0] bj;

  assign ai      = i_q[MA-1:0];
  assign ak      = k_q[NA-1:0];
  assign bj      = j_q[PA-1:0];
  assign word_d  = {word_q, bus.rx_data};
  assign loading = (state_q == HDR) ||
                   (state_q == LOAD_A) ||
                   (state_q == LOAD_B);
  assign wdone   = loading && bus.rx_valid &&
                   (bcnt_q == 2'd3);
  assign i_last  = (i_q == m_q - MW'(1));
  assign j_last  = (j_q == p_q - PW'(1));
  assign k_last  = (k_q == n_q - NW'(1));

  // The one and only multiplier; low 32 bits wrap modulo 2^32.
  assign prod  = a_q[ai][ak] * b_q[ak][bj];
  assign acc_d = ((k_q == '0) ? 32'd0 : acc_q) + prod;
  assign c_rd  = c_q[ai][bj];

  // For a 1x1 result C[0][0] is written on the same edge it is first read.
  assign c_first = (m_q == MW'(1) && p_q == PW'(1)) ?
                   acc_d : c_q[0][0];

  always_comb begin
    lim = 32'(MAX_P);
    unique case (hcnt_q)
      2'd0:    lim = 32'(MAX_M);
      2'd1:    lim = 32'(MAX_N);
      default: lim = 32'(MAX_P);
    endcase
  end

  assign dim_ok = (word_d != 32'd0) && (word_d <= lim);

  always_comb begin
    byte_sel = c_rd[7:0];
    unique case (bcnt_q)
      2'd0:    byte_sel = c_rd[31:24];
      2'd1:    byte_sel = c_rd[23:16];
      2'd2:    byte_sel = c_rd[15:8];
      default: byte_sel = c_rd[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD_A && wdone)
      a_q[ai][ak] <= word_d;
    if (state_q == LOAD_B && wdone)
      b_q[ak][bj] <= word_d;
    if (state_q == COMPUTE && k_last)
      c_q[ai][bj] <= acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR;
      bcnt_q     <= '0;
      hcnt_q     <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      n_q        <= '0;
      p_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (loading && bus.rx_valid) begin
        word_q <= word_d[23:0];
        bcnt_q <= bcnt_q + 2'd1;
      end
      unique case (state_q)
        HDR: if (wdone) begin
          if (!dim_ok) begin
            err_q  <= 1'b1;
            hcnt_q <= '0;
          end else begin
            unique case (hcnt_q)
              2'd0:    m_q <= word_d[MW-1:0];
              2'd1:    n_q <= word_d[NW-1:0];
              default: p_q <= word_d[PW-1:0];
            endcase
            hcnt_q <= hcnt_q + 2'd1;
            if (hcnt_q == 2'd2) begin
              state_q <= LOAD_A;
              hcnt_q  <= '0;
              i_q     <= '0;
              k_q     <= '0;
            end
          end
        end
        LOAD_A: if (wdone) begin
          if (k_last) begin
            k_q <= '0;
            if (i_last) begin
              state_q <= LOAD_B;
              i_q     <= '0;
              j_q     <= '0;
            end else begin
              i_q <= i_q + MW'(1);
            end
          end else begin
            k_q <= k_q + NW'(1);
          end
        end
        LOAD_B: if (wdone) begin
          if (j_last) begin
            j_q <= '0;
            if (k_last) begin
              state_q <= COMPUTE;
              busy_q  <= 1'b1;
              k_q     <= '0;
              i_q     <= '0;
            end else begin
              k_q <= k_q + NW'(1);
            end
          end else begin
            j_q <= j_q + PW'(1);
          end
        end
        COMPUTE: begin
          acc_q <= acc_d;
          if (k_last) begin
            k_q <= '0;
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                state_q    <= SEND;
                i_q        <= '0;
                bcnt_q     <= '0;
                tx_valid_q <= 1'b1;
                tx_data_q  <= c_first[31:24];
              end else begin
                i_q <= i_q + MW'(1);
              end
            end else begin
              j_q <= j_q + PW'(1);
            end
          end else begin
            k_q <= k_q + NW'(1);
          end
        end
        SEND: begin
          if (tx_valid_q) begin
            if (bus.tx_ready) begin
              tx_valid_q <= 1'b0;
              bcnt_q     <= bcnt_q + 2'd1;
              if (bcnt_q == 2'd3) begin
                if (j_last) begin
                  j_q <= '0;
                  if (i_last) begin
                    state_q <= HDR;
                    i_q     <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end else begin
                    i_q <= i_q + MW'(1);
                  end
                end else begin
                  j_q <= j_q + PW'(1);
                end
              end
            end
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= byte_sel;
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer.
// Hand-computed C values, checked byte by byte.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_sequencer_if bus();

  matmul_sequencer #(
    .MAX_M(4), .MAX_N(4), .MAX_P(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;
  logic [31:0] av [16];
  logic [31:0] bv [16];
  logic [31:0] ce [16];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int s = 3; s >= 0; s--)
      send_byte(w[8*s +: 8]);
  endtask

  task automatic inject(input bit bp);
    if (bp) begin
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic run_job(input int m, input int n, input int p,
                         input bit bp, input int abort_at);
    int cnt;
    int idx;
    int nb;
    logic prev_stall;
    logic [7:0] prev_data;
    logic [7:0] eb;
    send_word(32'(m));
    send_word(32'(n));
    send_word(32'(p));
    chk("hdr_err", 32'(bus.err), 0);
    for (int i = 0; i < m*n; i++) send_word(av[i]);
    for (int i = 0; i < n*p; i++) send_word(bv[i]);
    chk("busy_rise", 32'(bus.busy), 1);
    cnt = 0;
    while (!bus.tx_valid && cnt < 1000) begin
      @(negedge clk);
      inject(bp);
      #1;
      cnt++;
    end
    chk("compute_cycles", cnt, m*n*p);
    chk("busy_send", 32'(bus.busy), 1);
    nb = 4*m*p;
    idx = 0;
    cnt = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (idx < nb && cnt < 4000) begin
      bus.tx_ready = bp ? 1'($urandom) : 1'b1;
      inject(bp);
      #1;
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.tx_valid), 1);
        chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        eb = 8'(ce[idx/4] >> (8*(3 - idx%4)));
        chk("byte", 32'(bus.tx_data), 32'(eb));
        idx++;
        if (idx == abort_at) begin
          rst = 1'b1;
          #1;
          chk("rst_txv", 32'(bus.tx_valid), 0);
          chk("rst_busy", 32'(bus.busy), 0);
          chk("rst_done", 32'(bus.done), 0);
          bus.rx_valid = 1'b0;
          bus.tx_ready = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      @(negedge clk);
      cnt++;
    end
    if (idx < nb) chk("send_timeout", idx, nb);
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    #1;
    chk("done_pulse", 32'(bus.done), 1);
    chk("busy_fall", 32'(bus.busy), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("done_once", 32'(bus.done), 0);
      chk("no_extra", 32'(bus.tx_valid), 0);
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < 4; i++) begin
      av[i] = 32'(i + 1);
      bv[i] = 32'(i + 5);
    end
    ce[0] = 32'd19;
    ce[1] = 32'd22;
    ce[2] = 32'd43;
    ce[3] = 32'd50;
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_busy0", 32'(bus.busy), 0);
    chk("rst_done0", 32'(bus.done), 0);
    chk("rst_err0", 32'(bus.err), 0);

    set_basic();
    run_job(2, 2, 2, 1'b0, 0);

    av[0] = 1; av[1] = 2; av[2] = 3; av[3] = 4;
    bv[0] = 10; bv[1] = 20; bv[2] = 30; bv[3] = 40;
    ce[0] = 32'h0000_012C;
    run_job(1, 4, 1, 1'b0, 0);

    av[0] = 32'hFFFF_FFFF;
    bv[0] = 32'd2;
    ce[0] = 32'hFFFF_FFFE;
    run_job(1, 1, 1, 1'b0, 0);

    send_word(32'd0);
    chk("err_m0", 32'(bus.err), 1);
    chk("err_m0_tx", 32'(bus.tx_valid), 0);
    send_word(32'd5);
    chk("err_m5", 32'(bus.err), 1);
    chk("err_m5_busy", 32'(bus.busy), 0);
    set_basic();
    run_job(2, 2, 2, 1'b0, 0);

    run_job(2, 2, 2, 1'b1, 0);

    run_job(2, 2, 2, 1'b0, 5);
    run_job(2, 2, 2, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      av[i] = (i/4 == i%4) ? 32'd1 : 32'd0;
      bv[i] = 32'(i + 1);
      ce[i] = 32'(i + 1);
    end
    run_job(4, 4, 4, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
